dpram_port_arbiter: RTL and testbench

Shares the 16x8 dual-port RAM (`dual_port_ram`) between NREQ independent requesters. Each cycle it picks up to two requests in round-robin order. The first goes to RAM port A, the second to port B. It blocks same-address write hazards and returns read data to the requester that issued the read. It sits directly in front of `dual_port_ram` and drives all of that RAM's control, address and data inputs.

---
 rtl/dpram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NREQ requesters.
// Grants up to two requests per cycle (port A, then port B) and routes read data back.
module dpram_port_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*DW-1:0] rsp_data,
    output logic               we_a,
    output logic               re_a,
    output logic               we_b,
    output logic               re_b,
    output logic [AW-1:0]      addr_a,
    output logic [AW-1:0]      addr_b,
    output logic [DW-1:0]      din_a,
    output logic [DW-1:0]      din_b,
    input  logic [DW-1:0]      dout_a,
    input  logic [DW-1:0]      dout_b
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [AW-1:0] r_addr  [NREQ];
    logic [DW-1:0] r_wdata [NREQ];
    logic [IW-1:0] scan_idx [NREQ];

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_nxt;
    logic [IW-1:0] last_idx;
    logic          gnt_a, gnt_b;
    logic [IW-1:0] idx_a, idx_b;

    logic          pend_a, pend_b;
    logic [IW-1:0] pidx_a, pidx_b;
    logic [DW-1:0] hold     [NREQ];
    logic [DW-1:0] rsp_word [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign r_addr[g]  = req_addr[g*AW +: AW];
        assign r_wdata[g] = req_wdata[g*DW +: DW];
    end

    // Rotated scan order starting at rr_ptr.
    always_comb begin
        logic [IW:0] sum;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            scan_idx[k] = sum[IW-1:0];
        end
    end

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        idx_a = '0;
        idx_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rst && req_valid[scan_idx[k]]) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    idx_a = scan_idx[k];
                end else if (!gnt_b) begin
                    // Same-address pair involving a write would race inside the RAM.
                    if (!((r_addr[scan_idx[k]] == r_addr[idx_a]) &&
                          (req_we[scan_idx[k]] || req_we[idx_a]))) begin
                        gnt_b = 1'b1;
                        idx_b = scan_idx[k];
                    end
                end
            end
        end
    end

    always_comb begin
        last_idx = gnt_b ? idx_b : idx_a;
        if (last_idx == IW'(NREQ - 1)) begin
            rr_nxt = '0;
        end else begin
            rr_nxt = last_idx + IW'(1);
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (gnt_a && (idx_a == IW'(i))) || (gnt_b && (idx_b == IW'(i)));
        end
    end

    always_comb begin
        we_a   = gnt_a && req_we[idx_a];
        re_a   = gnt_a && !req_we[idx_a];
        addr_a = gnt_a ? r_addr[idx_a] : '0;
        din_a  = gnt_a ? r_wdata[idx_a] : '0;
        we_b   = gnt_b && req_we[idx_b];
        re_b   = gnt_b && !req_we[idx_b];
        addr_b = gnt_b ? r_addr[idx_b] : '0;
        din_b  = gnt_b ? r_wdata[idx_b] : '0;
    end

    // Read data is combinational from the RAM in the return cycle, held afterwards.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_word[i] = '0;
            if (!rst) begin
                if (pend_a && (pidx_a == IW'(i))) begin
                    rsp_valid[i] = 1'b1;
                    rsp_word[i]  = dout_a;
                end else if (pend_b && (pidx_b == IW'(i))) begin
                    rsp_valid[i] = 1'b1;
                    rsp_word[i]  = dout_b;
                end else begin
                    rsp_word[i] = hold[i];
                end
            end
            rsp_data[i*DW +: DW] = rsp_word[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            pidx_a <= '0;
            pidx_b <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold[i] <= '0;
            end
        end else begin
            if (gnt_a) begin
                rr_ptr <= rr_nxt;
            end
            pend_a <= re_a;
            pend_b <= re_b;
            pidx_a <= idx_a;
            pidx_b <= idx_b;
            for (int i = 0; i < NREQ; i++) begin
                hold[i] <= rsp_word[i];
            end
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM plus a rule-level reference model.
module tb_dpram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_we    = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic               we_a, re_a, we_b, re_b;
    logic [AW-1:0]      addr_a, addr_b;
    logic [DW-1:0]      din_a, din_b;
    logic [DW-1:0]      dout_a = '0;
    logic [DW-1:0]      dout_b = '0;

    logic [DW-1:0] mem [16] = '{default: '0};

    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (re_a) dout_a <= mem[addr_a];
        if (we_b) mem[addr_b] <= din_b;
        if (re_b) dout_b <= mem[addr_b];
    end

    dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .we_a      (we_a),
        .re_a      (re_a),
        .we_b      (we_b),
        .re_b      (re_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .din_a     (din_a),
        .din_b     (din_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b)
    );

    int            checks = 0;
    int            errors = 0;
    int            m_rr   = 0;
    bit [NREQ-1:0] m_rv   = '0;
    bit [NREQ-1:0] m_gnt  = '0;
    logic [DW-1:0] m_pdata [NREQ];
    logic [DW-1:0] m_hold  [NREQ];
    logic [DW-1:0] ref_mem [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] f_addr(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] f_wdata(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    task automatic set_req(input int i, input bit v, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]            = v;
        req_we[i]               = w;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: predict outputs from the rules, compare mid-cycle, then advance the model.
    task automatic step();
        int ord[$];
        int ga, gb, last;
        logic [NREQ-1:0]    e_rdy;
        logic [NREQ-1:0]    e_rv;
        logic [NREQ*DW-1:0] e_rd;
        logic [2*AW+2*DW+3:0] e_port;
        @(negedge clk);
        ga = -1;
        gb = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[(m_rr + k) % NREQ]) ord.push_back((m_rr + k) % NREQ);
            end
        end
        if (ord.size() > 0) ga = ord[0];
        for (int n = 1; n < ord.size(); n++) begin
            if (gb < 0 && !(f_addr(ord[n]) == f_addr(ga) && (req_we[ord[n]] || req_we[ga])))
                gb = ord[n];
        end
        e_rdy  = '0;
        e_port = '0;
        if (ga >= 0) begin
            e_rdy[ga] = 1'b1;
            e_port[2*AW+2*DW+3 -: AW+DW+2] = {req_we[ga], !req_we[ga], f_addr(ga), f_wdata(ga)};
        end
        if (gb >= 0) begin
            e_rdy[gb] = 1'b1;
            e_port[AW+DW+1:0] = {req_we[gb], !req_we[gb], f_addr(gb), f_wdata(gb)};
        end
        e_rv = rst ? '0 : m_rv;
        for (int i = 0; i < NREQ; i++) begin
            e_rd[i*DW +: DW] = rst ? '0 : (m_rv[i] ? m_pdata[i] : m_hold[i]);
        end
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("ram_ports", 64'({we_a, re_a, addr_a, din_a, we_b, re_b, addr_b, din_b}), 64'(e_port));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("rsp_data", 64'(rsp_data), 64'(e_rd));
        @(posedge clk);
        for (int i = 0; i < NREQ; i++) m_hold[i] = e_rd[i*DW +: DW];
        m_gnt = e_rdy;
        m_rv  = '0;
        if (rst) begin
            m_rr = 0;
        end else begin
            if (ga >= 0 && !req_we[ga]) begin
                m_rv[ga] = 1'b1;
                m_pdata[ga] = ref_mem[f_addr(ga)];
            end
            if (gb >= 0 && !req_we[gb]) begin
                m_rv[gb] = 1'b1;
                m_pdata[gb] = ref_mem[f_addr(gb)];
            end
            if (ga >= 0 && req_we[ga]) ref_mem[f_addr(ga)] = f_wdata(ga);
            if (gb >= 0 && req_we[gb]) ref_mem[f_addr(gb)] = f_wdata(gb);
            if (ga >= 0) begin
                last = (gb >= 0) ? gb : ga;
                m_rr = (last + 1) % NREQ;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            m_pdata[i] = '0;
            m_hold[i]  = '0;
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // Reset state
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 4'h1, 8'h11);
        step();
        step();
        rst = 1'b0;
        clear_all();

        // Write then read back
        set_req(0, 1'b1, 1'b1, 4'h5, 8'h3C);
        step();
        set_req(0, 1'b1, 1'b0, 4'h5, 8'h00);
        step();
        clear_all();
        step();

        // Four readers from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(i + 1), 8'h00);
        repeat (3) step();
        clear_all();
        step();

        // Write/write hazard on address 5
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'h5, 8'h11);
        set_req(1, 1'b1, 1'b1, 4'h5, 8'h22);
        set_req(2, 1'b1, 1'b0, 4'h7, 8'h00);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        step();
        clear_all();
        step();
        chk("hazard_mem5", 64'(mem[5]), 64'(8'h22));

        // Read/read same address
        set_req(0, 1'b1, 1'b1, 4'h9, 8'hA5);
        step();
        clear_all();
        set_req(1, 1'b1, 1'b0, 4'h9, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'h9, 8'h00);
        step();
        clear_all();
        step();

        // Idle
        repeat (5) step();

        // Reset while a read is in flight
        set_req(0, 1'b1, 1'b0, 4'h5, 8'h00);
        step();
        clear_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(2, 1'b1, 1'b0, 4'h9, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'h5, 8'h00);
        step();
        clear_all();
        step();

        // Random traffic with narrow addresses to provoke hazards
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                                DW'($urandom));
                    else
                        set_req(i, 1'b0, 1'b0, '0, '0);
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        clear_all();
        step();
        step();

        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
